// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: data width, register-index width and the
// writeback-buffer entry layout.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t          rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Priority match of one decode read address against the pending writeback
// entries; the youngest matching entry supplies the forwarded value.
module wb_fwd_match
  import riscv_pkg::REG_W;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic [DEPTH-1:0]         i_valid,
  input  logic [DEPTH*REG_W-1:0]   i_rd,
  input  logic [DEPTH*XLEN-1:0]    i_data,
  input  logic [$clog2(DEPTH)-1:0] i_head,
  input  logic [REG_W-1:0]         i_addr,
  output logic                     o_hit,
  output logic [XLEN-1:0]          o_data
);

  localparam int PW = $clog2(DEPTH);

  logic [REG_W-1:0] w_rd   [DEPTH];
  logic [XLEN-1:0]  w_data [DEPTH];
  logic [PW-1:0]    w_idx  [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_unpack
      assign w_rd[gi]   = i_rd[gi*REG_W +: REG_W];
      assign w_data[gi] = i_data[gi*XLEN +: XLEN];
      // w_idx[k] is the slot holding the k-th oldest entry
      assign w_idx[gi]  = i_head + PW'(gi);
    end
  endgenerate

  // Walk oldest to youngest so the last match written wins.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    if (i_addr != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (i_valid[w_idx[k]] && (w_rd[w_idx[k]] == i_addr)) begin
          o_hit  = 1'b1;
          o_data = w_data[w_idx[k]];
        end
      end
    end
  end

endmodule

// File: rtl/wb_buffer.sv
// In-order writeback buffer between the pipeline and the register-file
// write port, with forwarding of pending values to the decode read ports.
module wb_buffer
  import riscv_pkg::REG_W;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = riscv_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_W-1:0]         in_rd,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     drain_en,
  output logic                     rf_we,
  output logic [REG_W-1:0]         rf_a3,
  output logic [XLEN-1:0]          rf_wd,
  input  logic [REG_W-1:0]         A1,
  input  logic [REG_W-1:0]         A2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [XLEN-1:0]          fwd_data1,
  output logic [XLEN-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] r_valid;
  logic [REG_W-1:0] r_rd_mem   [DEPTH];
  logic [XLEN-1:0]  r_data_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic [DEPTH*REG_W-1:0] w_rd_flat;
  logic [DEPTH*XLEN-1:0]  w_data_flat;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // rd==0 beats are consumed but never stored (x0 is hardwired zero)
  assign w_push  = in_valid && !w_full && (in_rd != '0);
  assign w_pop   = !w_empty && drain_en;

  assign in_ready = !w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign rf_we    = w_pop;
  assign rf_a3    = w_empty ? '0 : r_rd_mem[r_rd_ptr];
  assign rf_wd    = w_empty ? '0 : r_data_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr          <= r_wr_ptr + PW'(1);
        r_valid[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr          <= r_rd_ptr + PW'(1);
        r_valid[r_rd_ptr] <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is left uncleared by reset; r_valid gates its use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_wr_ptr]   <= in_rd;
      r_data_mem[r_wr_ptr] <= in_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign w_rd_flat[gi*REG_W +: REG_W]  = r_rd_mem[gi];
      assign w_data_flat[gi*XLEN +: XLEN]  = r_data_mem[gi];
    end
  endgenerate

  wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd1 (
    .i_valid (r_valid),
    .i_rd    (w_rd_flat),
    .i_data  (w_data_flat),
    .i_head  (r_rd_ptr),
    .i_addr  (A1),
    .o_hit   (fwd_hit1),
    .o_data  (fwd_data1)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd2 (
    .i_valid (r_valid),
    .i_rd    (w_rd_flat),
    .i_data  (w_data_flat),
    .i_head  (r_rd_ptr),
    .i_addr  (A2),
    .o_hit   (fwd_hit2),
    .o_data  (fwd_data2)
  );

endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of pending-write entries (power of two, 2..8).
REQ-002 The block SHALL have parameter XLEN, default 32, meaning the data width of each entry.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  producer offers a writeback.
REQ-006 in_ready  output  1  buffer can accept a writeback this cycle.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_data  input  XLEN  writeback value.
REQ-009 drain_en  input  1  register-file write port is available this cycle.
REQ-010 rf_we  output  1  register-file write enable.
REQ-011 rf_a3  output  5  register-file write address.
REQ-012 rf_wd  output  XLEN  register-file write data.
REQ-013 A1, A2  input  5 each  read addresses presented to the register file by decode.
REQ-014 fwd_hit1, fwd_hit2  output  1 each  a pending entry matches A1 / A2.
REQ-015 fwd_data1, fwd_data2  output  XLEN each  value of the youngest matching entry.
REQ-016 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-017 empty  output  1  count == 0.

Function
REQ-018 The block SHALL be an in-order FIFO of {rd, data} entries; it accepts an entry when in_valid && in_ready at a posedge.
REQ-019 in_ready SHALL be 1 iff count < DEPTH; a full buffer does not accept, even if it drains in the same cycle.
REQ-020 A handshake with in_rd == 0 SHALL complete (consume the beat) but SHALL NOT allocate an entry or change count.
REQ-021 rf_we SHALL equal (!empty && drain_en) combinationally; rf_a3/rf_wd SHALL present the head entry whenever !empty, and zero when empty.
REQ-022 When rf_we == 1 at a posedge, the head entry SHALL be removed at that edge.
REQ-023 Minimum latency SHALL be 1 cycle: an entry accepted at edge N drives rf_we from cycle N+1 if drain_en is high.
REQ-024 A simultaneous enqueue and dequeue (not full) SHALL leave count unchanged and preserve order.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-026 fwd_hitN SHALL be 1 iff AN != 0 and some occupied entry has rd == AN, including the head entry being drained this cycle.
REQ-027 fwd_dataN SHALL be the data of the youngest (most recently enqueued) matching entry, and zero when fwd_hitN == 0.
REQ-028 An in-flight beat on in_* in the current cycle SHALL NOT be forwarded; it becomes visible from the next cycle.
REQ-029 Multiple pending entries to the same rd SHALL all be retained and drained in order; none are coalesced.

Reset
REQ-030 Reset assertion SHALL immediately clear count, both pointers, and every entry's valid bit, regardless of the clock.
REQ-031 During and after reset: in_ready = 1, empty = 1, count = 0, rf_we = 0, rf_a3 = 0, rf_wd = 0, fwd_hit1/2 = 0, fwd_data1/2 = 0.
REQ-032 Pending entries at reset assertion SHALL be discarded; entry data storage need not be cleared.

Structure
REQ-033 XLEN, register-index width (5), and the wb entry struct/typedef SHALL live in the shared package riscv_pkg.
REQ-034 The priority match SHALL be one sub-module, wb_fwd_match, instantiated twice (once each for A1 and A2), taking entry valid/rd/data plus the age order and returning hit/data.

Verification
REQ-035 Reset, then enqueue rd=5/0xDEADBEEF with drain_en=1 -> next cycle rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF; following cycle empty=1.
REQ-036 With drain_en=0, enqueue 4 entries -> count=4, in_ready=0; a 5th in_valid is not accepted; raise drain_en -> 4 writes, in order.
REQ-037 Enqueue rd=3/0x11 then rd=3/0x22 with drain_en=0, A1=3 -> fwd_hit1=1, fwd_data1=0x22; after one drain, still 0x22; after two drains, fwd_hit1=0.
REQ-038 Enqueue rd=0/0xFFFF -> handshake completes, count stays 0, no rf_we; A2=0 -> fwd_hit2=0.
REQ-039 With count=2, enqueue and drain in the same cycle -> count stays 2; pointers wrap across 3 full fill/drain cycles with order preserved.
REQ-040 Assert reset mid-cycle with 3 entries pending -> count=0, rf_we=0, fwd_hit1/2=0 immediately, without waiting for a clock edge.
